// File: rtl/ahblite_seg_scan_pkg.sv
// Shared register map, CTRL field positions and the hex-to-segment decode
// used by the 7-segment scanner.
package seg_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_EN_LSB  = 0;
  localparam int CTRL_DP_LSB  = 8;
  localparam int CTRL_SCAN_EN = 31;

  // Active-high {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/ahblite_seg_scan_timer.sv
// Slot counter and digit index for the display scan; blank flag marks the
// leading part of every slot where no anode may be driven.
module seg_scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 28672,
  parameter int BLANK_CYC  = 64
)(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       run,
  input  logic       clr,
  output logic [2:0] idx,
  output logic       blank
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt;

  // clr comes from the next-cycle SCAN_EN so a disabling write beats a wrap
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt <= '0;
      idx <= '0;
    end else if (clr) begin
      cnt <= '0;
      idx <= '0;
    end else if (run) begin
      if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign blank = (cnt < CW'(BLANK_CYC));

endmodule

// File: rtl/ahblite_seg_scan.sv
// AHB-Lite slave holding digit data / enable / dp masks and driving a
// time-multiplexed 7-segment bank through registered an/seg_led outputs.
module ahblite_seg_scan import seg_pkg::*; #(
  parameter int NUM_DIGITS      = 4,
  parameter int SCAN_DIV        = 28672,
  parameter int BLANK_CYC       = 64,
  parameter int AN_ACTIVE_LOW   = 1,
  parameter int SEG_ACTIVE_HIGH = 1
)(
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [7:0]            seg_led,
  output logic [NUM_DIGITS-1:0] an
);

  localparam logic [31:0] DATA_MASK = 32'hFFFF_FFFF >> (32 - 4*NUM_DIGITS);
  localparam logic [31:0] EN_MASK   = 32'h0000_00FF >> (8 - NUM_DIGITS);
  localparam logic [31:0] CTRL_MASK = EN_MASK | (EN_MASK << CTRL_DP_LSB) | (32'd1 << CTRL_SCAN_EN);
  localparam logic [31:0] CTRL_RST  = EN_MASK | (32'd1 << CTRL_SCAN_EN);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;

  logic        ph_vld, ph_wr;
  logic [1:0]  ph_reg, ph_lo, ph_size;
  logic [3:0]  strb;
  logic [31:0] bmask, data_q, data_d, ctrl_q, ctrl_d;
  logic        wr_en, blank, lit;
  logic [2:0]  idx;
  logic [7:0]  en_bits, dp_bits, seg_act;
  logic [3:0]  nib;
  logic [NUM_DIGITS-1:0] an_act;
  logic        unused_ok;

  assign unused_ok = ^{HADDR[31:4], HSIZE[2], HPROT, HTRANS[0]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  // Address phase capture; zero wait states, so HREADY gates every phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ph_vld  <= 1'b0;
      ph_wr   <= 1'b0;
      ph_reg  <= '0;
      ph_lo   <= '0;
      ph_size <= '0;
    end else if (HREADY) begin
      ph_vld  <= HSEL & HTRANS[1];
      ph_wr   <= HWRITE;
      ph_reg  <= HADDR[3:2];
      ph_lo   <= HADDR[1:0];
      ph_size <= HSIZE[1:0];
    end
  end

  always_comb begin
    strb = '0;
    case (ph_size)
      2'd0:    strb[ph_lo] = 1'b1;
      2'd1:    strb = ph_lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  assign bmask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  assign wr_en = ph_vld & ph_wr;

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (wr_en && ph_reg == REG_DATA)
      data_d = ((data_q & ~bmask) | (HWDATA & bmask)) & DATA_MASK;
    if (wr_en && ph_reg == REG_CTRL)
      ctrl_d = ((ctrl_q & ~bmask) | (HWDATA & bmask)) & CTRL_MASK;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      data_q <= '0;
      ctrl_q <= CTRL_RST;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC)
  ) u_timer (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .run     (ctrl_q[CTRL_SCAN_EN]),
    .clr     (~ctrl_d[CTRL_SCAN_EN]),
    .idx     (idx),
    .blank   (blank)
  );

  always_comb begin
    HRDATA = '0;
    if (ph_vld && !ph_wr) begin
      case (ph_reg)
        REG_DATA:   HRDATA = data_q;
        REG_CTRL:   HRDATA = ctrl_q;
        REG_STATUS: HRDATA = {23'd0, blank, 5'd0, idx};
        default:    HRDATA = '0;
      endcase
    end
  end

  // Disabled digits keep their slot but stay dark
  assign en_bits = ctrl_q[CTRL_EN_LSB +: 8];
  assign dp_bits = ctrl_q[CTRL_DP_LSB +: 8];
  assign nib     = data_q[{idx, 2'b00} +: 4];
  assign lit     = ctrl_q[CTRL_SCAN_EN] & ~blank & en_bits[idx];
  assign seg_act = lit ? {dp_bits[idx], hex_to_seg(nib)} : 8'h00;

  always_comb begin
    an_act = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      an_act[i] = lit && (idx == 3'(i));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      an      <= AN_OFF;
      seg_led <= SEG_OFF;
    end else begin
      an      <= (AN_ACTIVE_LOW != 0) ? ~an_act : an_act;
      seg_led <= (SEG_ACTIVE_HIGH != 0) ? seg_act : ~seg_act;
    end
  end

endmodule

// File: tb/tb_ahblite_seg_scan.sv
// Randomized scoreboard bench: a slot/time reference model predicts the
// display every cycle and a queue carries expected read data to the monitor.
module tb_ahblite_seg_scan;

  localparam int ND  = 4;
  localparam int DIV = 40;
  localparam int BL  = 8;
  localparam logic [31:0] DMASK    = 32'h0000_FFFF;
  localparam logic [31:0] CMASK    = 32'h8000_0F0F;
  localparam logic [31:0] CTRL_RST = 32'h8000_000F;

  logic        HCLK = 1'b0, HRESETn = 1'b1;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = '0;
  logic [3:0]  HPROT = '0;
  logic        HREADYOUT, HRESP;
  logic [31:0] HRDATA;
  logic [7:0]  seg_led;
  logic [ND-1:0] an;

  ahblite_seg_scan #(
    .NUM_DIGITS(ND), .SCAN_DIV(DIV), .BLANK_CYC(BL),
    .AN_ACTIVE_LOW(1), .SEG_ACTIVE_HIGH(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .seg_led(seg_led), .an(an)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        is_status;
    logic [31:0] exp;
    string       name;
  } rd_t;

  rd_t rdq[$];
  int  n_cmp = 0, n_bad = 0;

  // shadow registers as the bus sees them; previous-cycle model state
  logic [31:0] m_data = '0, m_ctrl = CTRL_RST;
  logic [31:0] p_data = '0, p_ctrl = CTRL_RST;
  int          p_t = 0;

  logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: display vs model every cycle, read data whenever a read data phase is queued
  initial begin
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        chk("rst_an", 32'(an), 32'h0000_000F);
        chk("rst_seg", 32'(seg_led), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        p_t = 0; p_ctrl = CTRL_RST; p_data = '0;
      end else begin
        int pos, dig, cur_t;
        logic lit;
        logic [3:0] nb;
        logic [31:0] e_an, e_seg, e_rd;
        pos = p_t % DIV;
        dig = (p_t / DIV) % ND;
        nb  = p_data[dig*4 +: 4];
        lit = p_ctrl[31] && (pos >= BL) && p_ctrl[dig];
        e_an  = lit ? (32'h0000_000F & ~(32'd1 << dig)) : 32'h0000_000F;
        e_seg = lit ? {24'd0, p_ctrl[8+dig], HEX[nb]} : 32'h0;
        chk("disp_an", 32'(an), e_an);
        chk("disp_seg", 32'(seg_led), e_seg);
        cur_t = !m_ctrl[31] ? 0 : (p_ctrl[31] ? p_t + 1 : 0);
        p_t = cur_t; p_ctrl = m_ctrl; p_data = m_data;
        if (rdq.size() > 0) begin
          rd_t r;
          r = rdq.pop_front();
          e_rd = r.exp;
          if (r.is_status) begin
            e_rd = '0;
            e_rd[2:0] = 3'((cur_t / DIV) % ND);
            e_rd[8]   = ((cur_t % DIV) < BL);
          end
          chk(r.name, HRDATA, e_rd);
        end
      end
    end
  end

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] r;
    r = (addr[3:2] == 2'd0) ? m_data : m_ctrl;
    for (int b = 0; b < 4; b++) begin
      logic hit;
      hit = (size == 3'd0) ? (b == int'(addr[1:0])) :
            (size == 3'd1) ? ((b / 2) == int'(addr[1])) : 1'b1;
      if (hit) r[8*b +: 8] = wd[8*b +: 8];
    end
    if (addr[3:2] == 2'd0) m_data = r & DMASK;
    else if (addr[3:2] == 2'd1) m_ctrl = r & CMASK;
  endtask

  // Called and returns at posedge+1
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, input logic [1:0] trans = 2'b10,
                      input logic rdy = 1'b1);
    logic taken;
    taken = trans[1] && rdy;
    HSEL = 1'b1; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size; HREADY = rdy;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; HWDATA = wd;
    if (taken && !wr) begin
      rd_t r;
      r.is_status = (addr[3:2] == 2'd2);
      r.exp  = (addr[3:2] == 2'd0) ? m_data : (addr[3:2] == 2'd1) ? m_ctrl : 32'h0;
      r.name = $sformatf("read_%0h", addr[3:0]);
      rdq.push_back(r);
    end
    @(posedge HCLK); #1;
    if (taken && wr) model_write(addr, size, wd);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic found;
    #1 HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;

    xfer(0, 32'h0, 3'd2, 0);
    xfer(0, 32'h4, 3'd2, 0);
    xfer(0, 32'h8, 3'd2, 0);

    xfer(1, 32'h0, 3'd2, 32'h0000_1234);
    xfer(0, 32'h0, 3'd2, 0);
    idle(ND * DIV + 20);

    xfer(1, 32'h1, 3'd0, 32'h0000_AB00);
    xfer(1, 32'h2, 3'd1, 32'hFFFF_0000);
    xfer(0, 32'h0, 3'd2, 0);

    // BUSY and HREADY-low address phases must be ignored
    xfer(1, 32'h0, 3'd2, 32'h0000_5555, 2'b01);
    xfer(1, 32'h0, 3'd2, 32'h0000_6666, 2'b10, 1'b0);
    xfer(0, 32'h0, 3'd2, 0);

    xfer(1, 32'h4, 3'd2, 32'h8000_0205);
    xfer(0, 32'h4, 3'd2, 0);
    idle(ND * DIV + 10);

    // Clear SCAN_EN with the data phase landing on the slot's last cycle
    found = 1'b0; k = 0;
    while (!found && k < 200) begin
      if ((p_t + 1) % DIV == DIV - 2) found = 1'b1;
      else idle(1);
      k++;
    end
    chk("wrap_align_found", 32'(found), 32'd1);
    xfer(1, 32'h4, 3'd2, 32'h0000_0205);
    xfer(0, 32'h8, 3'd2, 0);
    idle(15);
    xfer(1, 32'h4, 3'd2, 32'h8000_000F);
    idle(2 * DIV);

    repeat (60) begin
      logic [31:0] a, wd;
      logic [2:0]  sz;
      a  = $urandom & 32'hFFFF_FFF0;
      a[3:2] = 2'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 2));
      if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 3'd1) a[1] = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a[3:2] == 2'd1 && $urandom_range(0, 4) != 0) wd[31] = 1'b1;
      if ($urandom_range(0, 1) == 1) xfer(1, a, sz, wd);
      else xfer(0, a, 3'd2, 0);
      idle($urandom_range(0, 60));
    end

    // Async reset in the middle of a write data phase
    xfer(1, 32'h4, 3'd2, 32'h8000_0F0F);
    idle(DIV / 2 + BL);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0000_FFFF;
    #2 HRESETn = 1'b0;
    m_data = '0; m_ctrl = CTRL_RST;
    @(negedge HCLK); @(negedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(0, 32'h0, 3'd2, 0);
    xfer(0, 32'h4, 3'd2, 0);
    idle(DIV + 5);

    chk("queue_drained", 32'(rdq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
